// File: rtl/tinyriscv_pkg.sv
// Shared definitions for the tinyriscv execute stage: divide opcodes,
// divide-initiator state encoding and the divide-by-zero quotient value.
package tinyriscv_pkg;

    // Divide/remainder opcodes as presented by the decoder (funct3 encoding).
    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    // Divide initiator states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_issue_state_t;

    // Quotient returned for a zero divisor. It is kept signed so that a
    // size cast to any datapath width sign-extends to all-ones.
    localparam logic signed [31:0] DIV_BY_ZERO_QUOT = -32'sd1;

    // True for the quotient-producing ops; remainder ops return the dividend
    // when the divisor is zero.
    function automatic logic is_quotient_op(input logic [2:0] op);
        return (op == INST_DIV) || (op == INST_DIVU);
    endfunction

endpackage

// File: rtl/div_issue_ctrl_fixup.sv
// div_result_fixup: applies the RISC-V divide-by-zero result rules.
// Purely combinational; used both for results coming back from the divider
// and for locally resolved zero-divisor requests.
module div_result_fixup
    import tinyriscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic             error,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] raw_result,
    output logic [WIDTH-1:0] wdata
);

    // Pass the divider result through unless a zero divisor was seen.
    always_comb begin
        wdata = raw_result;
        if (error) begin
            if (is_quotient_op(op)) begin
                wdata = WIDTH'(DIV_BY_ZERO_QUOT);
            end else begin
                wdata = dividend;
            end
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: execute-stage initiator for the iterative divider.
// Latches the operands of a DIV/DIVU/REM/REMU, holds the divider valid/operand
// handshake while stalling the pipeline, fixes up divide-by-zero results and
// emits a single-cycle register writeback. A flush aborts the divide by
// dropping valid.
// Optional feature macro: DIV_ZERO_BYPASS_EN -- when defined, a zero divisor
// is resolved locally without ever asserting div_valid_o.
module div_issue_ctrl
    import tinyriscv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic [2:0]            op_i,
    input  logic [WIDTH-1:0]      reg1_rdata_i,
    input  logic [WIDTH-1:0]      reg2_rdata_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  wb_we_o,
    output logic [REG_ADDR_W-1:0] wb_waddr_o,
    output logic [WIDTH-1:0]      wb_wdata_o,
    output logic                  div_valid_o,
    output logic [WIDTH-1:0]      div_dividend_o,
    output logic [WIDTH-1:0]      div_divisor_o,
    output logic [2:0]            div_op_o,
    input  logic [WIDTH-1:0]      div_data_i,
    input  logic                  div_ready_i,
    input  logic                  div_error_i
);

    div_issue_state_t state;
    div_issue_state_t state_next;

    logic [WIDTH-1:0]      dividend_q;
    logic [WIDTH-1:0]      divisor_q;
    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [WIDTH-1:0]      wdata_q;

    logic                  start;
    logic                  capture;
    logic                  bypass;
    logic                  stall_raw;

    logic [2:0]            fix_op;
    logic                  fix_error;
    logic [WIDTH-1:0]      fix_dividend;
    logic [WIDTH-1:0]      fix_raw;
    logic [WIDTH-1:0]      fix_wdata;

    // State register with immediate return to IDLE on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/control outputs.
    always_comb begin
        state_next  = state;
        stall_raw   = 1'b0;
        busy_o      = 1'b0;
        div_valid_o = 1'b0;
        wb_we_o     = 1'b0;
        start       = 1'b0;
        capture     = 1'b0;
        bypass      = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (req_i && !flush_i) begin
                    stall_raw  = 1'b1;
                    start      = 1'b1;
                    state_next = DIV_BUSY;
`ifdef DIV_ZERO_BYPASS_EN
                    if (reg2_rdata_i == '0) begin
                        bypass     = 1'b1;
                        state_next = DIV_DONE;
                    end
`endif
                end
            end
            DIV_BUSY: begin
                div_valid_o = 1'b1;
                busy_o      = 1'b1;
                if (flush_i) begin
                    state_next = DIV_IDLE;
                end else begin
                    stall_raw = 1'b1;
                    if (div_ready_i) begin
                        capture    = 1'b1;
                        state_next = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                wb_we_o    = !flush_i && (rd_q != '0);
                state_next = DIV_IDLE;
            end
            default: begin
                state_next = DIV_IDLE;
            end
        endcase
        stall_o = stall_raw && rst_ni;
    end

    // Select fix-up inputs: the live request for a local zero-divisor
    // resolution, otherwise the latched operands and the divider response.
    always_comb begin
        fix_op       = op_q;
        fix_error    = div_error_i;
        fix_dividend = dividend_q;
        fix_raw      = div_data_i;
`ifdef DIV_ZERO_BYPASS_EN
        if (state == DIV_IDLE) begin
            fix_op       = op_i;
            fix_error    = 1'b1;
            fix_dividend = reg1_rdata_i;
            fix_raw      = '0;
        end
`endif
    end

    div_result_fixup #(
        .WIDTH(WIDTH)
    ) u_fixup (
        .op        (fix_op),
        .error     (fix_error),
        .dividend  (fix_dividend),
        .raw_result(fix_raw),
        .wdata     (fix_wdata)
    );

    // Operand latches and writeback result register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else begin
            if (start) begin
                dividend_q <= reg1_rdata_i;
                divisor_q  <= reg2_rdata_i;
                op_q       <= op_i;
                rd_q       <= rd_addr_i;
            end
            if (capture || bypass) begin
                wdata_q <= fix_wdata;
            end
        end
    end

    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign div_op_o       = op_q;
    assign wb_waddr_o     = rd_q;
    assign wb_wdata_o     = wdata_q;

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Execute-stage initiator for the iterative divider: accepts a decoded DIV/DIVU/REM/REMU from EX and drives the divider's valid/operand/op handshake.
- Stalls the pipeline while the divide is in flight, applies the RISC-V divide-by-zero result rules, and produces a single-cycle register writeback.
- Handles pipeline flush by aborting the divider, which drops valid.

Parameters:
- WIDTH, 32, operand/result width
- REG_ADDR_W, 5, destination register address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  divide instruction present in EX
- op_i  in  3  INST_DIV/INST_DIVU/INST_REM/INST_REMU (package codes)
- reg1_rdata_i  in  WIDTH  dividend
- reg2_rdata_i  in  WIDTH  divisor
- rd_addr_i  in  REG_ADDR_W  destination register
- flush_i  in  1  pipeline flush (jump/interrupt)
- stall_o  out  1  hold EX and earlier stages
- busy_o  out  1  divide in flight
- wb_we_o  out  1  register write enable, 1-cycle pulse
- wb_waddr_o  out  REG_ADDR_W  write address
- wb_wdata_o  out  WIDTH  write data
- div_valid_o  out  1  request to divider; level, held until ready
- div_dividend_o  out  WIDTH  latched dividend
- div_divisor_o  out  WIDTH  latched divisor
- div_op_o  out  3  latched op
- div_data_i  in  WIDTH  divider result
- div_ready_i  in  1  divider result valid
- div_error_i  in  1  divider saw divisor==0

Behaviour:
- Reset: async, active-low. Asserting rst_ni=0 forces state IDLE immediately, including mid-operation. All registered outputs and latches become 0: div_valid_o, div operands/op, wb_* and busy_o. stall_o is 0 while in reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On req_i & ~flush_i: latch reg1/reg2/op/rd and go to BUSY.
  - stall_o = req_i & ~flush_i, combinational in the same cycle.
- BUSY:
  - div_valid_o=1; operands/op stable from the latches; stall_o=1; busy_o=1.
  - On div_ready_i: capture the result and go to DONE.
  - Result capture: div_error_i=0 -> div_data_i. div_error_i=1 -> DIV/DIVU give all-ones; REM/REMU give the latched dividend.
- DONE:
  - div_valid_o=0, so the divider is guaranteed to return to its idle state; stall_o=0; busy_o=0.
  - wb_we_o=1 for exactly this cycle, with wb_waddr_o/wb_wdata_o valid; then go to IDLE.
  - req_i in DONE is ignored: it is the same instruction leaving EX.
- div_valid_o is always low for at least one cycle between two requests.
- Latency: req_i to wb_we_o = (cycles for the divider to raise ready after valid) + 1. Stall is released in the writeback cycle.
- flush_i:
  - In BUSY: go to IDLE next cycle; div_valid_o drops, which aborts the divider; no writeback; stall_o=0 in the flush cycle.
  - In DONE: suppresses wb_we_o, which is gated combinationally.
  - flush_i together with req_i in IDLE: no start.
- rd_addr_i==0: the divide still executes; wb_we_o is suppressed.
- div_ready_i outside BUSY is ignored.
- Signed overflow (-2^(WIDTH-1) / -1) is passed through from the divider without fix-up.

Optional Feature:
- DIV_ZERO_BYPASS_EN defined: in IDLE, req_i with reg2_rdata_i==0 goes straight to DONE. The fix-up result is applied locally, div_valid_o is never asserted, and wb_we_o fires the cycle after req_i.
- Undefined: divide-by-zero is issued to the divider and fixed up from div_error_i.

Decomposition:
- tinyriscv_pkg: INST_DIV/DIVU/REM/REMU (existing), div_issue_state_t enum, DIV_BY_ZERO_QUOT constant (all-ones).
- One combinational sub-module, div_result_fixup: op, error, dividend and raw result in; final writeback data out. It is shared by the BUSY capture path and the bypass path.

Test Plan:
- DIV -7/2, rd=5 -> stall_o high from req through BUSY. Single wb_we_o pulse with waddr=5, wdata=0xFFFFFFFD. div_valid_o low in DONE.
- DIVU 9/0 and REMU 100/0, macro off -> divider issued, error returned; wdata 0xFFFFFFFF and 100. With DIV_ZERO_BYPASS_EN: div_valid_o never high, wb the cycle after req.
- DIV 20/3, flush_i 10 cycles into BUSY -> div_valid_o 0 next cycle, no wb_we_o. Re-issue then gives wdata 6.
- REM 17/5 with rd=0 -> full handshake occurs, wb_we_o never asserted.
- rst_ni low mid-BUSY -> div_valid_o, stall_o, busy_o go 0 asynchronously. After release, REM -17/5 gives 0xFFFFFFFE.
- Back-to-back DIV 100/7 then REMU 100/7, req_i held in DONE -> writebacks of 14 then 2. div_valid_o has at least one low cycle between requests; the held req_i in DONE does not start a divide.
